memwrite_checker: RTL
=====================

// Module: memwrite_checker
// PURPOSE
//  Synthesizable self-check monitor that sits on the CPU data-memory write bus
//  (memwrite/dataaddr/writedata) beside the processor top. Holds a table of up
//  to DEPTH expected (address, data) stores and checks that they occur in order.
//  Reports pass, fail (with capture of the offending store) or timeout, so one
//  bench, or an FPGA LED, can grade any test program with multiple checkpoints.
// PARAMETERS
//  AW       32    address width
//  DW       32    data width
//  DEPTH    4     expected-table entries (power of 2, >=2)
//  IDXW     2     log2(DEPTH)
//  TIMEOUT  1000  cycles allowed in ARMED before TMO; 0 disables the timeout
//  STRICT   0     1: an early store to a later entry's address is a FAIL
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     synchronous, active-high
//  memwrite   in   1     store strobe from CPU
//  dataaddr   in   AW    store address
//  writedata  in   DW    store data
//  cfg_we     in   1     write table entry cfg_idx
//  cfg_idx    in   IDXW  table index
//  cfg_addr   in   AW    expected address
//  cfg_data   in   DW    expected data
//  cfg_count  in   IDXW+1 number of active entries, sampled on start
//  start      in   1     arm the checker
//  busy       out  1     state==ARMED
//  done       out  1     state in {PASS,FAIL,TMO}
//  pass       out  1     state==PASS
//  timeout    out  1     state==TMO
//  match_cnt  out  IDXW+1 entries matched so far
//  fail_idx   out  IDXW  entry index at failure
//  fail_addr  out  AW    captured store address at failure
//  fail_data  out  DW    captured store data at failure
// BEHAVIOUR
//  - All outputs registered; reset -> IDLE, every output 0, table cleared to 0.
//  - States: IDLE, ARMED, PASS, FAIL, TMO. PASS/FAIL/TMO hold until reset/start.
//  - cfg_we honoured in IDLE/PASS/FAIL/TMO; ignored in ARMED.
//  - start in any non-ARMED state: latch cnt=cfg_count, ptr=0, timer=0,
//    match_cnt=0, fail_* =0 -> ARMED next edge. start in ARMED ignored.
//    cfg_we and start on the same edge: the write lands; checking uses new value.
//  - cfg_count==0 or >DEPTH on start -> FAIL, fail_idx=all ones, fail_*=0.
//  - In ARMED, per edge with memwrite=1:
//    dataaddr==tbl[ptr].addr & writedata==tbl[ptr].data: match_cnt++, ptr++;
//      if ptr==cnt-1 -> PASS.
//    dataaddr==tbl[ptr].addr, data differs -> FAIL, capture idx/addr/data.
//    STRICT=1 and dataaddr equals tbl[j].addr for ptr<j<cnt (not tbl[ptr].addr)
//      -> FAIL, fail_idx=ptr, capture addr/data.
//    any other store ignored. memwrite=0: no table action.
//  - Latency: store sampled at edge N -> outputs reflect result after edge N.
//  - Timer increments each ARMED cycle; TIMEOUT>0 and timer==TIMEOUT-1 with no
//    terminal event that edge -> TMO. Final match and timeout same edge -> PASS.
//  - Repeated matching store after ptr advanced is checked against new ptr.
//  - reset mid-ARMED aborts to IDLE; table contents lost.
// TESTING
//  T1 table {(80,5),(84,7)}, cnt=2, start; stores 80<-5, 60<-1, 84<-7 ->
//     pass=1 one edge after 84<-7, match_cnt=2, busy=0.
//  T2 same table; stores 80<-5, 84<-9 -> FAIL, fail_idx=1, fail_addr=84,
//     fail_data=9, match_cnt=1.
//  T3 STRICT=1, same table; store 84<-7 first -> FAIL fail_idx=0, fail_addr=84;
//     STRICT=0 same stimulus -> ignored, stays ARMED.
//  T4 TIMEOUT=20, cnt=1, no stores -> timeout=1 exactly 20 cycles after ARMED;
//     final match on cycle 20 -> pass=1, timeout=0.
//  T5 start with cfg_count=0 -> FAIL, fail_idx=3; then cfg_count=1, start ->
//     ARMED, fail_* cleared.
//  T6 reset asserted while ARMED after 1 match -> next edge all outputs 0,
//     IDLE; cfg_we during ARMED leaves table unchanged.

Source files
------------

// File: rtl/memwrite_checker_if.sv
// CPU data-memory store bus as seen by the write checker.
// memwrite is a valid-only strobe: a store is taken on every edge it is high, and the checker is always ready.
interface memwrite_checker_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          memwrite;
    logic [AW-1:0] dataaddr;
    logic [DW-1:0] writedata;

    modport master (output memwrite, output dataaddr, output writedata);
    modport slave  (input  memwrite, input  dataaddr, input  writedata);
endinterface

// File: rtl/memwrite_checker.sv
// Store-sequence monitor: compares CPU stores against a table of expected
// (address, data) pairs in order and reports pass, fail with capture, or timeout.
module memwrite_checker #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int IDXW    = 2,
    parameter int TIMEOUT = 1000,
    parameter int STRICT  = 0
) (
    input  logic            clk,
    input  logic            reset,
    memwrite_checker_if.slave bus,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_data,
    input  logic [IDXW:0]   cfg_count,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [IDXW:0]   match_cnt,
    output logic [IDXW-1:0] fail_idx,
    output logic [AW-1:0]   fail_addr,
    output logic [DW-1:0]   fail_data,
    output logic [2:0]      state_dbg
);
    localparam int CW = IDXW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        PASS  = 3'd2,
        FAIL  = 3'd3,
        TMO   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [31:0]     timer_q, timer_d;
    logic [CW-1:0]   match_q, match_d;
    logic [IDXW-1:0] fidx_q, fidx_d;
    logic [AW-1:0]   faddr_q, faddr_d;
    logic [DW-1:0]   fdata_q, fdata_d;

    logic [AW-1:0]   tbl_addr [DEPTH];
    logic [DW-1:0]   tbl_data [DEPTH];

    logic hit_addr, hit_data, strict_hit, terminal;

    // The table is frozen while armed so the running check sees a stable target.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_addr[i] <= '0;
                tbl_data[i] <= '0;
            end
        end else if (cfg_we && state_q != ARMED) begin
            tbl_addr[cfg_idx] <= cfg_addr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            match_q <= '0;
            fidx_q  <= '0;
            faddr_q <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            match_q <= match_d;
            fidx_q  <= fidx_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
        end
    end

    always_comb begin
        hit_addr   = (bus.dataaddr == tbl_addr[ptr_q]);
        hit_data   = (bus.writedata == tbl_data[ptr_q]);
        strict_hit = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (CW'(j) > {1'b0, ptr_q} && CW'(j) < cnt_q && bus.dataaddr == tbl_addr[j])
                strict_hit = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        match_d  = match_q;
        fidx_d   = fidx_q;
        faddr_d  = faddr_q;
        fdata_d  = fdata_q;
        terminal = 1'b0;
        case (state_q)
            ARMED: begin
                timer_d = timer_q + 32'd1;
                if (bus.memwrite) begin
                    if (hit_addr && hit_data) begin
                        match_d = match_q + CW'(1);
                        ptr_d   = ptr_q + IDXW'(1);
                        if ({1'b0, ptr_q} == cnt_q - CW'(1)) begin
                            state_d  = PASS;
                            terminal = 1'b1;
                        end
                    end else if (hit_addr || (STRICT != 0 && strict_hit)) begin
                        state_d  = FAIL;
                        terminal = 1'b1;
                        fidx_d   = ptr_q;
                        faddr_d  = bus.dataaddr;
                        fdata_d  = bus.writedata;
                    end
                end
                // A final match on the expiry edge wins over the timeout.
                if (!terminal && TIMEOUT > 0 && timer_q == 32'(TIMEOUT - 1))
                    state_d = TMO;
            end
            default: begin
                if (start) begin
                    cnt_d   = cfg_count;
                    ptr_d   = '0;
                    timer_d = '0;
                    match_d = '0;
                    fidx_d  = '0;
                    faddr_d = '0;
                    fdata_d = '0;
                    if (cfg_count == '0 || cfg_count > CW'(DEPTH)) begin
                        state_d = FAIL;
                        fidx_d  = '1;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end
        endcase
    end

    assign busy      = (state_q == ARMED);
    assign done      = (state_q == PASS) || (state_q == FAIL) || (state_q == TMO);
    assign pass      = (state_q == PASS);
    assign timeout   = (state_q == TMO);
    assign match_cnt = match_q;
    assign fail_idx  = fidx_q;
    assign fail_addr = faddr_q;
    assign fail_data = fdata_q;
    assign state_dbg = state_q;
endmodule
